// File: rtl/reorder_buffer_if.sv
// Interface for the reorder buffer: the issue, CDB, operand query, commit and flush signals.
interface reorder_buffer_if #(
    parameter int IDX_W = 4
);
    logic             issue_en;
    logic [4:0]       issue_rd;
    logic             issue_is_br;
    logic             issue_pred_taken;
    logic             full;
    logic             upd;
    logic [IDX_W-1:0] upd_idx;
    logic [4:0]       upd_rd;
    logic             cdb_en;
    logic [IDX_W-1:0] cdb_idx;
    logic [31:0]      cdb_val;
    logic             cdb_taken;
    logic [31:0]      cdb_pc;
    logic [IDX_W-1:0] rs1_pos;
    logic [IDX_W-1:0] rs2_pos;
    logic             rs1_ready;
    logic             rs2_ready;
    logic [31:0]      rs1_val;
    logic [31:0]      rs2_val;
    logic             write;
    logic [IDX_W-1:0] write_idx;
    logic [4:0]       write_rd;
    logic [31:0]      new_val;
    logic             jp_wrong;
    logic [31:0]      jp_pc;

    modport master (
        output issue_en, issue_rd, issue_is_br, issue_pred_taken,
        output cdb_en, cdb_idx, cdb_val, cdb_taken, cdb_pc,
        output rs1_pos, rs2_pos,
        input  full, upd, upd_idx, upd_rd,
        input  rs1_ready, rs2_ready, rs1_val, rs2_val,
        input  write, write_idx, write_rd, new_val, jp_wrong, jp_pc
    );

    modport slave (
        input  issue_en, issue_rd, issue_is_br, issue_pred_taken,
        input  cdb_en, cdb_idx, cdb_val, cdb_taken, cdb_pc,
        input  rs1_pos, rs2_pos,
        output full, upd, upd_idx, upd_rd,
        output rs1_ready, rs2_ready, rs1_val, rs2_val,
        output write, write_idx, write_rd, new_val, jp_wrong, jp_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// 16-entry in-order-retire reorder buffer with branch mispredict flush.
// Optional macro ROB_CDB_BYPASS_EN forwards a same-cycle CDB result to the operand queries.
module reorder_buffer #(
    parameter int IDX_W = 4
) (
    input logic            clk,
    input logic            rst,
    input logic            rdy,
    reorder_buffer_if.slave rob
);
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(DEPTH);

    logic [DEPTH-1:0] busy, ready, is_br, pred, taken;
    logic [4:0]       rd  [DEPTH];
    logic [31:0]      val [DEPTH];
    logic [31:0]      pc  [DEPTH];
    logic [IDX_W-1:0] head, tail;
    logic [IDX_W:0]   count;
    logic             commit, mispredict, cdb_ok;

    always_comb begin
        rob.full    = (count == FULL_CNT);
        rob.upd     = rdy & rob.issue_en & ~rob.full & ~rob.jp_wrong;
        rob.upd_idx = tail;
        rob.upd_rd  = rob.issue_rd;
        commit      = (count != '0) & ready[head];
        mispredict  = commit & is_br[head] & (taken[head] != pred[head]);
        // Broadcasts to freed entries or during a flush pulse are dropped.
        cdb_ok      = rob.cdb_en & ~rob.jp_wrong & busy[rob.cdb_idx];
    end

    always_comb begin
        rob.rs1_ready = ready[rob.rs1_pos];
        rob.rs1_val   = val[rob.rs1_pos];
        rob.rs2_ready = ready[rob.rs2_pos];
        rob.rs2_val   = val[rob.rs2_pos];
`ifdef ROB_CDB_BYPASS_EN
        if (rob.cdb_en && rob.cdb_idx == rob.rs1_pos) begin
            rob.rs1_ready = 1'b1;
            rob.rs1_val   = rob.cdb_val;
        end
        if (rob.cdb_en && rob.cdb_idx == rob.rs2_pos) begin
            rob.rs2_ready = 1'b1;
            rob.rs2_val   = rob.cdb_val;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy          <= '0;
            ready         <= '0;
            is_br         <= '0;
            pred          <= '0;
            taken         <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rd[i]  <= '0;
                val[i] <= '0;
                pc[i]  <= '0;
            end
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            rob.write     <= 1'b0;
            rob.write_idx <= '0;
            rob.write_rd  <= '0;
            rob.new_val   <= '0;
            rob.jp_wrong  <= 1'b0;
            rob.jp_pc     <= '0;
        end else if (rdy) begin
            rob.write    <= commit;
            rob.jp_wrong <= mispredict;
            if (commit) begin
                rob.write_idx <= head;
                rob.write_rd  <= rd[head];
                rob.new_val   <= val[head];
            end
            if (mispredict) begin
                rob.jp_pc <= pc[head];
            end
            if (cdb_ok) begin
                ready[rob.cdb_idx] <= 1'b1;
                val[rob.cdb_idx]   <= rob.cdb_val;
                taken[rob.cdb_idx] <= rob.cdb_taken;
                pc[rob.cdb_idx]    <= rob.cdb_pc;
            end
            // The flush clause comes last so it overrides the CDB write and any allocation.
            if (mispredict) begin
                busy  <= '0;
                ready <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (commit) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + 1'b1;
                end
                if (rob.upd) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    rd[tail]    <= rob.issue_rd;
                    is_br[tail] <= rob.issue_is_br;
                    pred[tail]  <= rob.issue_pred_taken;
                    tail        <= tail + 1'b1;
                end
                unique case ({rob.upd, commit})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed vector table, hand sequences, randomized model run.
module tb_reorder_buffer;
    logic clk;
    logic rst;
    logic rdy;

    reorder_buffer_if #(.IDX_W(4)) rob_if ();

    reorder_buffer #(.IDX_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .rob (rob_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ROB_CDB_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ien, input logic [4:0] rd, input logic br, input logic pr,
                         input logic cen, input logic [3:0] cidx, input logic [31:0] cval,
                         input logic ct, input logic [31:0] cpc,
                         input logic [3:0] p1, input logic [3:0] p2);
        rob_if.issue_en         = ien;
        rob_if.issue_rd         = rd;
        rob_if.issue_is_br      = br;
        rob_if.issue_pred_taken = pr;
        rob_if.cdb_en           = cen;
        rob_if.cdb_idx          = cidx;
        rob_if.cdb_val          = cval;
        rob_if.cdb_taken        = ct;
        rob_if.cdb_pc           = cpc;
        rob_if.rs1_pos          = p1;
        rob_if.rs2_pos          = p2;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0);
    endtask

    typedef struct {
        logic        ien;
        logic [4:0]  rd;
        logic        br;
        logic        pred;
        logic        cen;
        logic [3:0]  cidx;
        logic [31:0] cval;
        logic        ctaken;
        logic [31:0] cpc;
        logic [3:0]  rs1;
        logic        e_upd;
        logic [3:0]  e_uidx;
        logic        e_full;
        logic        e_r1rdy;
        logic [31:0] e_r1val;
        logic        e_wr;
        logic [3:0]  e_widx;
        logic [4:0]  e_wrd;
        logic [31:0] e_wval;
        logic        e_jp;
        logic [31:0] e_jpc;
    } vec_t;

    vec_t tbl[20];

    // Reference model: in-order queue of live entries, entry index = allocation slot.
    typedef struct {
        logic [3:0]  idx;
        logic [4:0]  rd;
        logic        br;
        logic        pred;
        logic        done;
        logic        taken;
        logic [31:0] val;
        logic [31:0] pc;
    } ment_t;

    ment_t       q[$];
    int          mhead;
    logic        m_wr, m_jp;
    logic [3:0]  m_widx;
    logic [4:0]  m_wrd;
    logic [31:0] m_wval, m_jpc;

    function automatic int find(input logic [3:0] idx);
        foreach (q[k]) if (q[k].idx == idx) return k;
        return -1;
    endfunction

    task automatic model_reset();
        q.delete();
        mhead  = 0;
        m_wr   = 1'b0;
        m_jp   = 1'b0;
        m_widx = '0;
        m_wrd  = '0;
        m_wval = '0;
        m_jpc  = '0;
    endtask

    task automatic query_exp(input logic [3:0] pos, output logic r, output logic [31:0] v);
        int p;
        p = find(pos);
        r = (p >= 0) ? q[p].done : 1'b0;
        v = (p >= 0) ? q[p].val : 32'd0;
        if (BYP && rob_if.cdb_en && rob_if.cdb_idx == pos) begin
            r = 1'b1;
            v = rob_if.cdb_val;
        end
    endtask

    task automatic random_cycle();
        logic        full_e, upd_e, r_e, br, pr, cen, ct;
        logic [3:0]  uidx_e, cidx, p1, p2;
        logic [31:0] v_e, cval, cpc;
        logic        c, mp, old_jp;
        int          p;
        rst = ($urandom_range(0, 299) == 0);
        rdy = ($urandom_range(0, 9) != 0);
        br  = ($urandom_range(0, 3) == 0);
        pr  = 1'($urandom_range(0, 1));
        cen = ($urandom_range(0, 1) == 1);
        if (q.size() > 0 && $urandom_range(0, 4) != 0) begin
            p    = $urandom_range(0, q.size() - 1);
            cidx = q[p].idx;
            ct   = ($urandom_range(0, 6) == 0) ? ~q[p].pred : q[p].pred;
        end else begin
            cidx = 4'($urandom_range(0, 15));
            ct   = 1'($urandom_range(0, 1));
        end
        cval = $urandom;
        cpc  = $urandom;
        p1   = (q.size() > 0) ? q[$urandom_range(0, q.size() - 1)].idx : 4'($urandom_range(0, 15));
        p2   = 4'($urandom_range(0, 15));
        drive(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 31)), br, pr, cen, cidx, cval, ct, cpc, p1, p2);
        #1;
        full_e = (q.size() == 16);
        upd_e  = rdy && rob_if.issue_en && !full_e && !m_jp;
        uidx_e = 4'((mhead + q.size()) % 16);
        if (!rst) begin
            chk("r_full", 32'(rob_if.full), 32'(full_e));
            chk("r_upd", 32'(rob_if.upd), 32'(upd_e));
            if (upd_e) begin
                chk("r_upd_idx", 32'(rob_if.upd_idx), 32'(uidx_e));
                chk("r_upd_rd", 32'(rob_if.upd_rd), 32'(rob_if.issue_rd));
            end
            query_exp(p1, r_e, v_e);
            chk("r_rs1_ready", 32'(rob_if.rs1_ready), 32'(r_e));
            if (r_e) chk("r_rs1_val", rob_if.rs1_val, v_e);
            query_exp(p2, r_e, v_e);
            chk("r_rs2_ready", 32'(rob_if.rs2_ready), 32'(r_e));
            if (r_e) chk("r_rs2_val", rob_if.rs2_val, v_e);
        end
        tick();
        if (rst) begin
            model_reset();
        end else if (rdy) begin
            c      = (q.size() > 0) && q[0].done;
            mp     = c && q[0].br && (q[0].taken != q[0].pred);
            old_jp = m_jp;
            m_wr   = c;
            m_jp   = mp;
            if (c) begin
                m_widx = q[0].idx;
                m_wrd  = q[0].rd;
                m_wval = q[0].val;
            end
            if (mp) m_jpc = q[0].pc;
            if (cen && !old_jp) begin
                p = find(cidx);
                if (p >= 0) begin
                    q[p].done  = 1'b1;
                    q[p].val   = cval;
                    q[p].taken = ct;
                    q[p].pc    = cpc;
                end
            end
            if (c) begin
                void'(q.pop_front());
                mhead = (mhead + 1) % 16;
            end
            if (upd_e) q.push_back('{idx: uidx_e, rd: rob_if.issue_rd, br: br, pred: pr,
                                     done: 1'b0, taken: 1'b0, val: 32'd0, pc: 32'd0});
            if (mp) begin
                q.delete();
                mhead = 0;
            end
        end
        chk("r_write", 32'(rob_if.write), 32'(m_wr));
        chk("r_write_idx", 32'(rob_if.write_idx), 32'(m_widx));
        chk("r_write_rd", 32'(rob_if.write_rd), 32'(m_wrd));
        chk("r_new_val", rob_if.new_val, m_wval);
        chk("r_jp_wrong", 32'(rob_if.jp_wrong), 32'(m_jp));
        chk("r_jp_pc", rob_if.jp_pc, m_jpc);
    endtask

    initial begin
        tbl[0]  = '{ien: 1, rd: 5, e_upd: 1, e_uidx: 0, default: 0};
        tbl[1]  = '{cen: 1, cidx: 0, cval: 'h1234, rs1: 0, e_r1rdy: BYP, e_r1val: 'h1234, default: 0};
        tbl[2]  = '{rs1: 0, e_r1rdy: 1, e_r1val: 'h1234, e_wr: 1, e_widx: 0, e_wrd: 5, e_wval: 'h1234, default: 0};
        tbl[3]  = '{ien: 1, rd: 1, e_upd: 1, e_uidx: 1, default: 0};
        tbl[4]  = '{ien: 1, rd: 2, e_upd: 1, e_uidx: 2, default: 0};
        tbl[5]  = '{ien: 1, rd: 3, e_upd: 1, e_uidx: 3, default: 0};
        tbl[6]  = '{cen: 1, cidx: 3, cval: 'hAB, rs1: 3, e_r1rdy: BYP, e_r1val: 'hAB, default: 0};
        tbl[7]  = '{cen: 1, cidx: 2, cval: 'h22, rs1: 3, e_r1rdy: 1, e_r1val: 'hAB, default: 0};
        tbl[8]  = '{cen: 1, cidx: 1, cval: 'h11, rs1: 4, default: 0};
        tbl[9]  = '{rs1: 4, e_wr: 1, e_widx: 1, e_wrd: 1, e_wval: 'h11, default: 0};
        tbl[10] = '{rs1: 4, e_wr: 1, e_widx: 2, e_wrd: 2, e_wval: 'h22, default: 0};
        tbl[11] = '{rs1: 4, e_wr: 1, e_widx: 3, e_wrd: 3, e_wval: 'hAB, default: 0};
        tbl[12] = '{rs1: 4, default: 0};
        tbl[13] = '{ien: 1, rd: 0, br: 1, pred: 0, rs1: 4, e_upd: 1, e_uidx: 4, default: 0};
        tbl[14] = '{ien: 1, rd: 7, rs1: 4, e_upd: 1, e_uidx: 5, default: 0};
        tbl[15] = '{cen: 1, cidx: 4, cval: 'h44, ctaken: 1, cpc: 'h100, rs1: 7, default: 0};
        tbl[16] = '{rs1: 4, e_r1rdy: 1, e_r1val: 'h44, e_wr: 1, e_widx: 4, e_wrd: 0, e_wval: 'h44,
                    e_jp: 1, e_jpc: 'h100, default: 0};
        tbl[17] = '{ien: 1, rd: 9, cen: 1, cidx: 5, cval: 'h99, rs1: 6, default: 0};
        tbl[18] = '{ien: 1, rd: 9, rs1: 5, e_upd: 1, e_uidx: 0, default: 0};
        tbl[19] = '{rs1: 5, default: 0};

        rst = 1'b1;
        rdy = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset_full", 32'(rob_if.full), 32'd0);
        chk("reset_upd", 32'(rob_if.upd), 32'd0);
        chk("reset_write", 32'(rob_if.write), 32'd0);
        chk("reset_jp_wrong", 32'(rob_if.jp_wrong), 32'd0);
        chk("reset_write_idx", 32'(rob_if.write_idx), 32'd0);
        chk("reset_write_rd", 32'(rob_if.write_rd), 32'd0);
        chk("reset_new_val", rob_if.new_val, 32'd0);
        chk("reset_jp_pc", rob_if.jp_pc, 32'd0);
        chk("reset_rs1_ready", 32'(rob_if.rs1_ready), 32'd0);

        // Directed vector table: basic commit, out-of-order completion, query, mispredict flush.
        foreach (tbl[i]) begin
            drive(tbl[i].ien, tbl[i].rd, tbl[i].br, tbl[i].pred, tbl[i].cen, tbl[i].cidx,
                  tbl[i].cval, tbl[i].ctaken, tbl[i].cpc, tbl[i].rs1, 4'd0);
            #1;
            chk($sformatf("v%0d_upd", i), 32'(rob_if.upd), 32'(tbl[i].e_upd));
            if (tbl[i].e_upd) chk($sformatf("v%0d_upd_idx", i), 32'(rob_if.upd_idx), 32'(tbl[i].e_uidx));
            if (tbl[i].e_upd) chk($sformatf("v%0d_upd_rd", i), 32'(rob_if.upd_rd), 32'(tbl[i].rd));
            chk($sformatf("v%0d_full", i), 32'(rob_if.full), 32'(tbl[i].e_full));
            chk($sformatf("v%0d_rs1_ready", i), 32'(rob_if.rs1_ready), 32'(tbl[i].e_r1rdy));
            if (tbl[i].e_r1rdy) chk($sformatf("v%0d_rs1_val", i), rob_if.rs1_val, tbl[i].e_r1val);
            tick();
            chk($sformatf("v%0d_write", i), 32'(rob_if.write), 32'(tbl[i].e_wr));
            if (tbl[i].e_wr) begin
                chk($sformatf("v%0d_write_idx", i), 32'(rob_if.write_idx), 32'(tbl[i].e_widx));
                chk($sformatf("v%0d_write_rd", i), 32'(rob_if.write_rd), 32'(tbl[i].e_wrd));
                chk($sformatf("v%0d_new_val", i), rob_if.new_val, tbl[i].e_wval);
            end
            chk($sformatf("v%0d_jp_wrong", i), 32'(rob_if.jp_wrong), 32'(tbl[i].e_jp));
            if (tbl[i].e_jp) chk($sformatf("v%0d_jp_pc", i), rob_if.jp_pc, tbl[i].e_jpc);
        end

        // Fill all 16 entries, block the 17th, commit idx 0 and wrap the tail.
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 5'(i + 1), 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0);
            #1;
            chk($sformatf("fill%0d_upd", i), 32'(rob_if.upd), 32'd1);
            chk($sformatf("fill%0d_upd_idx", i), 32'(rob_if.upd_idx), 32'(i));
            chk($sformatf("fill%0d_full", i), 32'(rob_if.full), 32'd0);
            tick();
        end
        drive(1'b1, 5'd17, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0);
        #1;
        chk("full_after_16", 32'(rob_if.full), 32'd1);
        chk("upd_17th", 32'(rob_if.upd), 32'd0);
        tick();
        drive(1'b1, 5'd17, 1'b0, 1'b0, 1'b1, 4'd0, 32'h77, 1'b0, 32'd0, 4'd0, 4'd0);
        #1;
        chk("upd_full_cdb", 32'(rob_if.upd), 32'd0);
        tick();
        drive(1'b1, 5'd17, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0);
        #1;
        chk("full_during_commit", 32'(rob_if.full), 32'd1);
        chk("upd_during_commit", 32'(rob_if.upd), 32'd0);
        tick();
        chk("wrap_write", 32'(rob_if.write), 32'd1);
        chk("wrap_write_idx", 32'(rob_if.write_idx), 32'd0);
        chk("wrap_write_rd", 32'(rob_if.write_rd), 32'd1);
        chk("wrap_new_val", rob_if.new_val, 32'h77);
        drive(1'b1, 5'd20, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0);
        #1;
        chk("wrap_full", 32'(rob_if.full), 32'd0);
        chk("wrap_upd", 32'(rob_if.upd), 32'd1);
        chk("wrap_upd_idx", 32'(rob_if.upd_idx), 32'd0);
        tick();
        idle();
        #1;
        chk("refull", 32'(rob_if.full), 32'd1);

        // Reset with a full buffer.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_full_full", 32'(rob_if.full), 32'd0);
        chk("rst_full_write", 32'(rob_if.write), 32'd0);

        // Stall with a ready head: nothing moves until rdy returns.
        drive(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0);
        tick();
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h55, 1'b0, 32'd0, 4'd0, 4'd0);
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0);
            #1;
            chk($sformatf("stall%0d_upd", i), 32'(rob_if.upd), 32'd0);
            tick();
            chk($sformatf("stall%0d_write", i), 32'(rob_if.write), 32'd0);
        end
        rdy = 1'b1;
        #1;
        chk("resume_upd", 32'(rob_if.upd), 32'd1);
        chk("resume_upd_idx", 32'(rob_if.upd_idx), 32'd1);
        tick();
        chk("resume_write", 32'(rob_if.write), 32'd1);
        chk("resume_write_idx", 32'(rob_if.write_idx), 32'd0);
        chk("resume_write_rd", 32'(rob_if.write_rd), 32'd3);
        chk("resume_new_val", rob_if.new_val, 32'h55);

        // Randomized run against the queue model.
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 4000; n++) random_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

16-entry circular reorder buffer that sits between the decoder/issue stage, the common data bus (CDB) and the architectural register file. It allocates an entry per issued instruction and emits the rename update (`upd`/`upd_idx`/`upd_rd`) that the register file consumes. It also captures execution results from the CDB and serves operand values to the decoder by ROB index. It retires strictly in order, driving the register file's `write`/`write_idx`/`write_rd`/`new_val` port, and raises `jp_wrong` with the corrected PC on a mispredicted branch.

## Interface
- `IDX_W`, 4, entry index width; depth = 2^IDX_W = 16.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rdy`  in  1  global enable; low freezes all state and registered outputs.
- `issue_en`  in  1  decoder presents an instruction this cycle.
- `issue_rd`  in  5  destination register (0 = none).
- `issue_is_br`  in  1  instruction is a branch/jump.
- `issue_pred_taken`  in  1  predictor's direction.
- `full`  out  1  no free entry (count == 16), combinational.
- `upd`  out  1  allocation accepted this cycle, combinational.
- `upd_idx`  out  IDX_W  allocated entry (= tail).
- `upd_rd`  out  5  equals `issue_rd`.
- `cdb_en`  in  1  result broadcast valid.
- `cdb_idx`  in  IDX_W  entry completing.
- `cdb_val`  in  32  result value.
- `cdb_taken`  in  1  actual branch direction.
- `cdb_pc`  in  32  correct next PC for a branch.
- `rs1_pos`, `rs2_pos`  in  IDX_W  entries queried by decoder.
- `rs1_ready`, `rs2_ready`  out  1  queried entry has its result.
- `rs1_val`, `rs2_val`  out  32  queried entry's value.
- `write`  out  1  registered commit strobe.
- `write_idx`  out  IDX_W  committed entry index.
- `write_rd`  out  5  committed destination.
- `new_val`  out  32  committed value.
- `jp_wrong`  out  1  registered flush pulse.
- `jp_pc`  out  32  redirect PC, valid while `jp_wrong`.

## Operation
- Per entry: `busy`, `ready`, `rd`, `val`, `is_br`, `pred`, `taken`, `pc`. Pointers `head`, `tail` (IDX_W bits, wrap mod 16) and `count` (IDX_W+1 bits).
- Allocate: `upd = issue_en & !full & !jp_wrong`. On the edge, write entry at `tail`, clear `ready`, `tail+1`, `count+1`. `issue_rd = 0` still allocates an entry; `upd` fires and the register file ignores rd 0.
- CDB: when `cdb_en`, the entry at `cdb_idx` gets `ready = 1`, `val`, `taken`, `pc`. A broadcast to a non-busy entry is ignored.
- Commit: when `count != 0` and head `ready`, on the edge: `write = 1`, `write_idx = head`, `write_rd`/`new_val` from the entry, free it, `head+1`, `count-1`. Otherwise `write = 0`. At most one commit per cycle.
- Mispredict: if the committing entry has `is_br` and `taken != pred`, the same edge also sets `jp_wrong = 1` and `jp_pc = pc`. All entries are cleared and head = tail = count = 0. A concurrent issue is dropped.
- While `jp_wrong = 1`, `upd` is forced to 0 and a CDB write is ignored. `jp_wrong` self-clears on the next enabled edge.
- Simultaneous allocate + commit: `count` is unchanged. A commit in the same cycle that `full` is high frees a slot only from the next cycle.
- Query: `rsN_ready = ready[rsN_pos]`, `rsN_val = val[rsN_pos]`, combinational.

## Timing
- Reset: all `busy`/`ready` = 0, head = tail = count = 0. `write`, `jp_wrong`, `write_idx`, `write_rd`, `new_val`, `jp_pc` = 0. `full` = 0.
- Issue to `upd`: 0 cycles (combinational). The register file latches on the same edge.
- CDB to commit eligibility: 1 cycle minimum; the earliest `write` is 2 edges after the CDB edge's cycle starts.
- `rdy` low: no pointer, entry or output register changes. `upd` is forced to 0.
- Reset mid-flush or with a full buffer: reset wins; the state above is restored in one edge.

## Configuration
- `ROB_CDB_BYPASS_EN` defined: if `cdb_en` and `cdb_idx == rsN_pos` in the current cycle, `rsN_ready = 1` and `rsN_val = cdb_val` (same-cycle forwarding).
- Not defined: the query sees only the stored entry state; the result becomes visible one cycle after the broadcast.

## Test plan
- Reset, then issue rd=5 (idx 0), CDB idx 0 val 0x1234 -> `upd=1, upd_idx=0, upd_rd=5`; two cycles later `write=1, write_idx=0, write_rd=5, new_val=0x1234`.
- Issue 16 without CDB -> `full=1` after the 16th, and the 17th `issue_en` gives `upd=0`. Complete idx 0 -> commit, then the next issue receives idx 0 (wrap).
- Complete entries out of order (2, 1, 0) -> commits emerge in order 0, 1, 2 on consecutive cycles.
- Branch at idx 0, pred=0, CDB taken=1, pc=0x100 -> `write=1` and `jp_wrong=1, jp_pc=0x100` on the same edge. The next cycle has count=0 and `upd=0` despite `issue_en`.
- Query rs1_pos=3 while CDB idx 3 val 0xAB -> with macro `rs1_ready=1, rs1_val=0xAB` same cycle; without macro the same values appear the next cycle.
- Drop `rdy` for 3 cycles with a ready head -> no `write` change and pointers held; commit occurs on the first edge with `rdy` high.
